sha256_compress: RTL
====================

// Module: sha256_compress
// PURPOSE
//  SHA-256 compression core: runs the 64 rounds over one 512-bit message block.
//  Drives the 6-bit address/enable into the round_constant ROM and consumes its
//  registered K_t output.
//  Produces the next 256-bit chaining value H_out = H_in + working vars (mod 2^32 per word).
//  Sits between the padding/block framer (upstream) and the digest output register (downstream).
// PARAMETERS
//  ADDR_WTH  6    round_constant ROM address width (64 rounds)
//  WRD_SIZE  32   SHA-256 word width; only 32 is supported
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     synchronous reset, active-high
//  i_start      in   1     1-cycle request; accepted only when o_busy=0
//  i_block      in   512   message block, word W0 = bits [511:480]
//  i_hash       in   256   chaining value H_in, H0 = bits [255:224]
//  o_rc_en      out  1     enable to round_constant ROM
//  o_rc_add     out  6     address to round_constant ROM
//  i_rc         in   32    K_t from ROM; valid 1 cycle after o_rc_add=t with o_rc_en=1
//  o_busy       out  1     high while a block is in flight
//  o_done       out  1     1-cycle pulse, o_hash valid
//  o_hash       out  256   H_out; held until the next accepted i_start
// BEHAVIOUR
//  Reset: state=IDLE, o_busy=0, o_done=0, o_rc_en=0, o_rc_add=0, o_hash=0, a..h=0, round cnt=0.
//  FSM states and transitions:
//   IDLE  -> PRIME on i_start: latch i_block into schedule, i_hash into h_in_q and a..h;
//            o_rc_en=1, o_rc_add=0.
//   PRIME -> ROUND (1 cycle): absorbs ROM latency. o_rc_add=1.
//   ROUND (t=0..63): one round per cycle using W_t and i_rc (=K_t). o_rc_add=t+2 (6-bit wrap, unused).
//         At t=63: o_hash <= h_in_q + updated a..h; o_done <= 1; state <= IDLE; o_rc_en <= 0.
//  Round update, all arithmetic mod 2^32:
//   T1 = h + S1(e) + Ch(e,f,g) + K_t + W_t;  T2 = S0(a) + Maj(a,b,c).
//   h=g; g=f; f=e; e=d+T1; d=c; c=b; b=a; a=T1+T2.
//  Latency:
//   i_start high in cycle N -> o_busy high N+1..N+65.
//   o_done high and o_hash valid in cycle N+66; o_busy=0 in N+66.
//  Back-to-back: i_start in cycle N+66 is accepted (IDLE); the o_done pulse still occurs.
//  i_start while o_busy=1 is ignored; it does not queue and does not disturb the rounds.
//  i_block and i_hash are sampled only on accept; they may change freely afterwards.
//  Reset mid-block: everything returns to reset values; no o_done is issued for the aborted block.
//  o_done is never asserted for more than 1 cycle; o_hash changes only on the done edge or on reset.
// STRUCTURE
//  sha256_pkg:
//   - word_t (logic [31:0]);
//   - SHA256_IV[0:7];
//   - functions ch, maj, bsig0/1 (S0,S1), ssig0/1 (s0,s1) and rotr.
//  Sub-module sha256_msg_sched:
//   - 16x32 shift register; load / shift inputs;
//   - output W_t = block word for t<16, else s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16];
//   - shifts once per ROUND cycle.
//  Top: FSM, 6-bit round counter, a..h registers, h_in_q, final adder, ROM address drive.
// TESTING (bench instantiates round_constant ROM + sha256_compress, i_hash=SHA256_IV)
//  1. "abc" block (W0=61626380, W1..W14=0, W15=00000018):
//     o_hash = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
//  2. Empty msg block (W0=80000000, rest 0):
//     o_hash = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
//  3. Timing: start at cycle N -> o_busy N+1..N+65, o_done exactly at N+66 for 1 cycle;
//     o_rc_add = 0,1,2.. starting N+1.
//  4. Start pulses at N+10 and N+40 while busy -> ignored; o_hash still equals case 1.
//     Back-to-back start at N+66 with case 2 block -> second digest correct.
//  5. reset high at N+30 for 1 cycle -> no o_done; all outputs 0 next cycle;
//     a fresh "abc" start then yields the case 1 digest.
//  6. Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
//     chain o_hash into i_hash ->
//     248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 shared types, initial hash value and round-function helpers.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam word_t SHA256_IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Block request / digest handshake between the framer and the compression core.
interface sha256_compress_if;
  logic         i_start;
  logic [511:0] i_block;
  logic [255:0] i_hash;
  logic         o_busy;
  logic         o_done;
  logic [255:0] o_hash;

  modport master (
    output i_start, i_block, i_hash,
    input  o_busy, o_done, o_hash
  );

  modport slave (
    input  i_start, i_block, i_hash,
    output o_busy, o_done, o_hash
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: 16-word sliding window, w[15] holds W_t.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block,
  output word_t        w_t
);

  word_t [15:0] w;
  word_t        w_next;

  // Window slot 15-k holds W_{t+k}; next word is W_{t+16}.
  always_comb begin
    w_next = ssig1(w[1]) + w[6] + ssig0(w[14]) + w[15];
  end

  assign w_t = w[15];

  // Load the block on accept, slide one word per round.
  always_ff @(posedge clk) begin
    if (reset) begin
      w <= '0;
    end else if (load) begin
      w <= block;
    end else if (shift) begin
      w <= {w[14:0], w_next};
    end
  end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression core: 64 rounds over one block, K_t fetched from an external ROM.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int ADDR_WTH = 6,
  parameter int WRD_SIZE = 32   // only 32 is supported
) (
  input  logic                clk,
  input  logic                reset,
  sha256_compress_if.slave    bus,
  output logic                o_rc_en,
  output logic [ADDR_WTH-1:0] o_rc_add,
  input  logic [WRD_SIZE-1:0] i_rc
);

  typedef enum logic [1:0] {IDLE, PRIME, ROUND} state_t;

  state_t              state;
  logic [ADDR_WTH-1:0] round;
  logic                busy_q;
  logic                done_q;
  logic [255:0]        hash_q;
  word_t [7:0]         h_in_q;
  word_t [7:0]         h_in_w;
  word_t               a, b, c, d, e, f, g, h;
  word_t               t1, t2, a_nxt, e_nxt;
  word_t               w_t;
  logic                accept;

  assign accept = (state == IDLE) && bus.i_start;
  assign h_in_w = bus.i_hash;

  sha256_msg_sched u_sched (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (state == ROUND),
    .block (bus.i_block),
    .w_t   (w_t)
  );

  // Round function for the current a..h, K_t and W_t.
  always_comb begin
    t1    = h + bsig1(e) + ch(e, f, g) + i_rc + w_t;
    t2    = bsig0(a) + maj(a, b, c);
    a_nxt = t1 + t2;
    e_nxt = d + t1;
  end

  // Control FSM, working registers, ROM address drive and final feed-forward add.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      round    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hash_q   <= '0;
      h_in_q   <= '0;
      o_rc_en  <= 1'b0;
      o_rc_add <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_start) begin
            state    <= PRIME;
            busy_q   <= 1'b1;
            round    <= '0;
            o_rc_en  <= 1'b1;
            o_rc_add <= '0;
            h_in_q   <= h_in_w;
            {a, b, c, d, e, f, g, h} <= h_in_w;
          end
        end
        PRIME: begin
          state    <= ROUND;
          o_rc_add <= ADDR_WTH'(1);
        end
        ROUND: begin
          a <= a_nxt;
          b <= a;
          c <= b;
          d <= c;
          e <= e_nxt;
          f <= e;
          g <= f;
          h <= g;
          round    <= round + ADDR_WTH'(1);
          // ROM output lags its address by one cycle, so fetch runs one ahead.
          o_rc_add <= o_rc_add + ADDR_WTH'(1);
          if (round == '1) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            o_rc_en <= 1'b0;
            hash_q  <= {h_in_q[7] + a_nxt, h_in_q[6] + a, h_in_q[5] + b, h_in_q[4] + c,
                        h_in_q[3] + e_nxt, h_in_q[2] + e, h_in_q[1] + f, h_in_q[0] + g};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
  assign bus.o_hash = hash_q;

endmodule
